// File: rtl/alu_pkg.sv
// Shared types for the multicycle ALU: opcode encoding and FSM state encoding.
// The MUL/DIV states only exist when ALU_MULDIV_EN is defined.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_NOP0   = 3'b000,
    ALU_ASSIGN = 3'b001,
    ALU_ADD    = 3'b010,
    ALU_SUB    = 3'b011,
    ALU_MUL    = 3'b100,
    ALU_DIV    = 3'b101,
    ALU_SHL    = 3'b110,
    ALU_NOP7   = 3'b111
  } alu_op_e;

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } alu_state_e;
`else
  typedef enum logic {
    ST_IDLE,
    ST_DONE
  } alu_state_e;
`endif

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative datapath: shift-add multiply and restoring divide, one bit per step.
// Exposes the post-step partials combinationally so the final step can be captured directly.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] lo_next,
  output logic [WIDTH-1:0] hi_next
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_rem;
  logic             div_fit;

  assign last = (cnt_q == CNT_LAST);

  // hi holds the running high product / partial remainder; lo holds the
  // multiplier being shifted out (MUL) or dividend-in/quotient-out (DIV).
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_fit   = (div_shift >= {1'b0, b_q});
    // Remainder is always below the divisor, so WIDTH bits suffice.
    div_rem   = div_shift[WIDTH-1:0] - b_q;
    if (is_div) begin
      hi_next = div_fit ? div_rem : div_shift[WIDTH-1:0];
      lo_next = {lo_q[WIDTH-2:0], div_fit};
    end else begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    if (load) begin
      hi_d  = '0;
      lo_d  = a;
      b_d   = b;
      cnt_d = '0;
    end else if (step) begin
      hi_d  = hi_next;
      lo_d  = lo_next;
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU top: single-cycle ASSIGN/ADD/SUB/SHL, iterative MUL/DIV.
// Define ALU_MULDIV_EN to build the MUL/DIV datapath; otherwise those opcodes return zeros.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] InputA,
  input  logic [WIDTH-1:0] InputB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Out1,
  output logic [WIDTH-1:0] Out2,
  output logic             Zero,
  output logic             DivByZero
);

  localparam logic [WIDTH-1:0] SHL_LIMIT = WIDTH'(WIDTH);

  alu_state_e       state_q, state_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic [WIDTH-1:0] out2_q, out2_d;
  logic             zero_q, zero_d;

  alu_op_e          op;
  logic [WIDTH-1:0] sc_out1;
  logic [WIDTH-1:0] sc_out2;

  assign op = alu_op_e'(OP);

`ifdef ALU_MULDIV_EN
  logic             dbz_q, dbz_d;
  logic             sc_dbz;
  logic             seq_load;
  logic             seq_step;
  logic             seq_last;
  logic [WIDTH-1:0] seq_lo;
  logic [WIDTH-1:0] seq_hi;

  alu_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .load    (seq_load),
    .step    (seq_step),
    .is_div  (state_q == ST_DIV),
    .a       (InputA),
    .b       (InputB),
    .last    (seq_last),
    .lo_next (seq_lo),
    .hi_next (seq_hi)
  );

  assign DivByZero = dbz_q;
`else
  assign DivByZero = 1'b0;
`endif

  // Results for every op that finishes on the Start edge itself.
  always_comb begin
    sc_out1 = '0;
    sc_out2 = '0;
`ifdef ALU_MULDIV_EN
    sc_dbz  = 1'b0;
`endif
    case (op)
      ALU_ASSIGN: sc_out1 = InputB;
      ALU_ADD:    sc_out1 = InputA + InputB;
      ALU_SUB:    sc_out1 = InputA - InputB;
      ALU_SHL:    sc_out1 = (InputB >= SHL_LIMIT) ? '0 : InputA << InputB;
`ifdef ALU_MULDIV_EN
      // Only reached with a zero divisor; nonzero divisors go iterative.
      ALU_DIV: begin
        sc_out1 = '1;
        sc_out2 = InputA;
        sc_dbz  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    out1_d  = out1_q;
    out2_d  = out2_q;
    zero_d  = zero_q;
`ifdef ALU_MULDIV_EN
    dbz_d    = dbz_q;
    seq_load = 1'b0;
    seq_step = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
`ifdef ALU_MULDIV_EN
          if (op == ALU_MUL) begin
            seq_load = 1'b1;
            state_d  = ST_MUL;
          end else if (op == ALU_DIV && InputB != '0) begin
            seq_load = 1'b1;
            state_d  = ST_DIV;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            out1_d  = sc_out1;
            out2_d  = sc_out2;
            zero_d  = (sc_out1 == '0);
            dbz_d   = sc_dbz;
          end
`else
          state_d = ST_DONE;
          done_d  = 1'b1;
          out1_d  = sc_out1;
          out2_d  = sc_out2;
          zero_d  = (sc_out1 == '0);
`endif
        end
      end
`ifdef ALU_MULDIV_EN
      ST_MUL, ST_DIV: begin
        seq_step = 1'b1;
        if (seq_last) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          out1_d  = seq_lo;
          out2_d  = seq_hi;
          zero_d  = (seq_lo == '0);
          dbz_d   = 1'b0;
        end
      end
`endif
      // Start seen here is dropped: DONE always falls back to IDLE.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: only control/result registers here, no memories; all take the async reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      out1_q  <= '0;
      out2_q  <= '0;
      zero_q  <= 1'b1;
`ifdef ALU_MULDIV_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      zero_q  <= zero_d;
`ifdef ALU_MULDIV_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign Busy = (state_q != ST_IDLE);
  assign Done = done_q;
  assign Out1 = out1_q;
  assign Out2 = out2_q;
  assign Zero = zero_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu (WIDTH=16): stimulus pushes expected results,
// a negedge monitor pops and compares on every Done pulse, including its cycle.
module tb_multicycle_alu;

  localparam int W = 16;
`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  localparam int unsigned MD_LAT = MD ? W + 1 : 1;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Start = 1'b0;
  logic [2:0]   OP = 3'b000;
  logic [W-1:0] InputA = '0;
  logic [W-1:0] InputB = '0;
  logic         Busy, Done, Zero, DivByZero;
  logic [W-1:0] Out1, Out2;

  multicycle_alu #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .OP        (OP),
    .InputA    (InputA),
    .InputB    (InputB),
    .Busy      (Busy),
    .Done      (Done),
    .Out1      (Out1),
    .Out2      (Out2),
    .Zero      (Zero),
    .DivByZero (DivByZero)
  );

  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    string        name;
    logic [W-1:0] o1;
    logic [W-1:0] o2;
    logic         z;
    logic         dz;
    int unsigned  at;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [W-1:0] last_o1 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    exp_t e;
    if (Done === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: Done=1 at cycle %0d, want no pulse", cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_cycle"}, cyc, e.at);
        check({e.name, "_out1"}, Out1, e.o1);
        check({e.name, "_out2"}, Out2, e.o2);
        check({e.name, "_zero"}, Zero, e.z);
        check({e.name, "_dbz"}, DivByZero, e.dz);
      end
    end
  end

  // Drive one Start cycle now and record its expected result; Done seen lat cycles later.
  task automatic drive(input string name, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] o1, input logic [W-1:0] o2,
                       input logic dz, input int unsigned lat);
    exp_t e;
    Start  = 1'b1;
    OP     = op;
    InputA = a;
    InputB = b;
    e.name = name;
    e.o1   = o1;
    e.o2   = o2;
    e.z    = (o1 == '0);
    e.dz   = dz;
    e.at   = cyc + lat;
    sb.push_back(e);
    last_o1 = o1;
  endtask

  task automatic issue(input string name, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] o1, input logic [W-1:0] o2,
                       input logic dz, input int unsigned lat, input int hold = 1);
    @(negedge Clk);
    drive(name, op, a, b, o1, o2, dz, lat);
    repeat (hold) @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(posedge Clk);
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: %0d results outstanding, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_out1", Out1, 16'h0000);
    check("rst_out2", Out2, 16'h0000);
    check("rst_zero", Zero, 1'b1);
    check("rst_dbz", DivByZero, 1'b0);

    // First Start lands on the very first edge after reset release.
    @(negedge Clk);
    Reset_n = 1'b1;
    drive("add_wrap", 3'b010, 16'hFFFF, 16'h0002, 16'h0001, 16'h0000, 1'b0, 1);
    @(negedge Clk);
    Start = 1'b0;
    wait_idle("add_wrap");

    issue("assign", 3'b001, 16'h1234, 16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1);
    wait_idle("assign");
    issue("sub_eq", 3'b011, 16'd3, 16'd3, 16'h0000, 16'h0000, 1'b0, 1);
    wait_idle("sub_eq");
    issue("sub_wrap", 3'b011, 16'd0, 16'd1, 16'hFFFF, 16'h0000, 1'b0, 1);
    wait_idle("sub_wrap");
    issue("shl_over", 3'b110, 16'd1, 16'd16, 16'h0000, 16'h0000, 1'b0, 1);
    wait_idle("shl_over");
    issue("shl_4", 3'b110, 16'd3, 16'd4, 16'h0030, 16'h0000, 1'b0, 1);
    wait_idle("shl_4");
    issue("shl_15", 3'b110, 16'h8001, 16'd15, 16'h8000, 16'h0000, 1'b0, 1);
    wait_idle("shl_15");
    issue("op7", 3'b111, 16'h5555, 16'h1111, 16'h0000, 16'h0000, 1'b0, 1);
    wait_idle("op7");
    issue("op0", 3'b000, 16'h5555, 16'h1111, 16'h0000, 16'h0000, 1'b0, 1);
    wait_idle("op0");

    issue("mul_a", 3'b100, 16'h1234, 16'h0100,
          MD ? 16'h3400 : 16'h0000, MD ? 16'h0012 : 16'h0000, 1'b0, MD_LAT);
    wait_idle("mul_a");
    issue("mul_max", 3'b100, 16'hFFFF, 16'hFFFF,
          MD ? 16'h0001 : 16'h0000, MD ? 16'hFFFE : 16'h0000, 1'b0, MD_LAT);
    wait_idle("mul_max");
    repeat (3) @(negedge Clk);
    check("hold_out1", Out1, last_o1);

    // DIV with a second Start arriving at cycle 5 of the operation.
    @(negedge Clk);
    drive("div_a", 3'b101, 16'd100, 16'd7,
          MD ? 16'd14 : 16'd0, MD ? 16'd2 : 16'd0, 1'b0, MD_LAT);
    @(negedge Clk);
    Start = 1'b0;
    check("div_busy", Busy, 1'b1);
    repeat (4) @(negedge Clk);
    check("div_busy_mid", Busy, MD);
    if (MD) begin
      Start = 1'b1;
      OP = 3'b010;
      InputA = 16'd1;
      InputB = 16'd1;
    end else begin
      drive("add_after_div", 3'b010, 16'd1, 16'd1, 16'd2, 16'd0, 1'b0, 1);
    end
    @(negedge Clk);
    Start = 1'b0;
    wait_idle("div_a");

    issue("div_zero", 3'b101, 16'd5, 16'd0,
          MD ? 16'hFFFF : 16'h0000, MD ? 16'd5 : 16'd0, MD, 1);
    wait_idle("div_zero");
    issue("add_clr_dbz", 3'b010, 16'd1, 16'd1, 16'd2, 16'd0, 1'b0, 1);
    wait_idle("add_clr_dbz");

    // Start held through the DONE cycle must not launch a second op.
    issue("add_hold", 3'b010, 16'd7, 16'd8, 16'h000F, 16'd0, 1'b0, 1, 2);
    wait_idle("add_hold");
    repeat (3) @(negedge Clk);

    // Reset at cycle 8 of a MUL: abort, no Done, outputs back to reset values.
    issue("mul_abort", 3'b100, 16'h1234, 16'h0100,
          MD ? 16'h3400 : 16'h0000, MD ? 16'h0012 : 16'h0000, 1'b0, MD_LAT);
    repeat (7) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    sb.delete();
    check("abort_busy", Busy, 1'b0);
    check("abort_done", Done, 1'b0);
    check("abort_out1", Out1, 16'h0000);
    check("abort_out2", Out2, 16'h0000);
    check("abort_zero", Zero, 1'b1);
    check("abort_dbz", DivByZero, 1'b0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (20) @(negedge Clk);

    issue("div_post", 3'b101, 16'd1000, 16'd33,
          MD ? 16'd30 : 16'd0, MD ? 16'd10 : 16'd0, 1'b0, MD_LAT);
    wait_idle("div_post");
    repeat (2) @(negedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
